// File: rtl/se_narrow_16b_12b.sv
// Registered 16b -> 12b signed narrowing stage with overflow detect, saturate/wrap
// select, valid/ready output handshake and debug overflow sticky flag/counter.
module se_narrow_16b_12b #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sat_mode,
  input  logic             clr,
  output logic [11:0]      out,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  logic             w_fit;
  logic             w_ovf;
  logic             w_accept;
  logic [11:0]      w_result;

  logic [11:0]      r_out;
  logic             r_out_ovf;
  logic             r_out_valid;
  logic             r_ovf_sticky;
  logic [CNT_W-1:0] r_ovf_count;

  // Fits in 12 bits signed iff the top five bits are a pure sign extension.
  assign w_fit = (in[15:11] == '0) || (in[15:11] == '1);
  assign w_ovf = !w_fit;

  always_comb begin
    w_result = in[11:0];
    if (w_ovf && sat_mode) begin
      w_result = in[15] ? 12'h800 : 12'h7FF;
    end
  end

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_result;
      r_out_ovf   <= w_ovf;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // An overflowing accept takes priority over clr, restarting the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= '0;
    end else if (w_accept && w_ovf) begin
      r_ovf_sticky <= 1'b1;
      if (clr) begin
        r_ovf_count <= CNT_W'(1);
      end else if (r_ovf_count != '1) begin
        r_ovf_count <= r_ovf_count + CNT_W'(1);
      end
    end else if (clr) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= '0;
    end
  end

  assign out        = r_out;
  assign out_ovf    = r_out_ovf;
  assign out_valid  = r_out_valid;
  assign ovf_sticky = r_ovf_sticky;
  assign ovf_count  = r_ovf_count;

endmodule

// File: tb/tb_se_narrow_16b_12b.sv
// Directed self-checking bench for se_narrow_16b_12b: one task per scenario,
// inputs driven 1 time unit after the rising edge, outputs sampled there too.
module tb_se_narrow_16b_12b;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        in_valid;
  logic        in_ready;
  logic        sat_mode;
  logic        clr;
  logic [11:0] out;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready;
  logic        ovf_sticky;
  logic [7:0]  ovf_count;

  int total = 0;
  int bad   = 0;

  logic        mon_en = 1'b0;
  logic [11:0] mon_q[$];

  se_narrow_16b_12b #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sat_mode   (sat_mode),
    .clr        (clr),
    .out        (out),
    .out_ovf    (out_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every value actually consumed downstream while enabled.
  always @(posedge clk) begin
    if (mon_en && out_valid && out_ready) mon_q.push_back(out);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=100000", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in = '0; in_valid = 1'b0; sat_mode = 1'b1; clr = 1'b0; out_ready = 1'b1;
    step(); step();
    total++; if (out !== 12'h000) begin bad++; $display("FAIL reset_out: got %h want 000", out); end
    total++; if (out_valid !== 1'b0 || out_ovf !== 1'b0) begin bad++; $display("FAIL reset_valid: got v=%b o=%b want 0 0", out_valid, out_ovf); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (ovf_sticky !== 1'b0 || ovf_count !== 8'h00) begin bad++; $display("FAIL reset_cnt: got s=%b c=%h want 0 00", ovf_sticky, ovf_count); end
    rst_n = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle: got v=%b want 0", out_valid); end
  endtask

  task automatic test_pass_through();
    in = 16'h0123; in_valid = 1'b1; sat_mode = 1'b1; out_ready = 1'b1;
    step();
    total++; if (out !== 12'h123 || out_ovf !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL pass_pos: got %h o=%b v=%b want 123 0 1", out, out_ovf, out_valid); end
    in = 16'hFFE1;
    step();
    total++; if (out !== 12'hFE1 || out_ovf !== 1'b0) begin bad++; $display("FAIL pass_neg: got %h o=%b want fe1 0", out, out_ovf); end
  endtask

  task automatic test_range_edges();
    logic [15:0] v_in  [0:4] = '{16'h07FF, 16'hF800, 16'h0800, 16'hF7FF, 16'h7FFF};
    logic [11:0] v_out [0:4] = '{12'h7FF, 12'h800, 12'h7FF, 12'h800, 12'h7FF};
    logic        v_ovf [0:4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    sat_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in = v_in[i];
      step();
      total++;
      if (out !== v_out[i] || out_ovf !== v_ovf[i]) begin
        bad++; $display("FAIL range_%0d: in=%h got %h o=%b want %h o=%b", i, v_in[i], out, out_ovf, v_out[i], v_ovf[i]);
      end
    end
    total++; if (ovf_count !== 8'd3 || ovf_sticky !== 1'b1) begin bad++; $display("FAIL range_cnt: got c=%0d s=%b want 3 1", ovf_count, ovf_sticky); end
  endtask

  task automatic test_wrap();
    sat_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in = 16'h1234;
    step();
    total++; if (out !== 12'h234 || out_ovf !== 1'b1) begin bad++; $display("FAIL wrap_1234: got %h o=%b want 234 1", out, out_ovf); end
    in = 16'h8000;
    step();
    total++; if (out !== 12'h000 || out_ovf !== 1'b1) begin bad++; $display("FAIL wrap_8000: got %h o=%b want 000 1", out, out_ovf); end
    total++; if (ovf_count !== 8'd5) begin bad++; $display("FAIL wrap_cnt: got %0d want 5", ovf_count); end
  endtask

  task automatic test_back_to_back_stall();
    sat_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in = 16'h0005;
    step();
    mon_en = 1'b1;
    mon_q.delete();
    total++; if (out !== 12'h005 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_first: got %h v=%b want 005 1", out, out_valid); end
    out_ready = 1'b0; in = 16'h0006;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_comb: got %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (out !== 12'h005 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_%0d: got %h v=%b r=%b want 005 1 0", i, out, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    total++; if (out !== 12'h006 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_release: got %h v=%b want 006 1", out, out_valid); end
    in_valid = 1'b0; in = 16'hxxxx; sat_mode = 1'bx;
    step();
    total++; if (out_valid !== 1'b0 || out !== 12'h006) begin bad++; $display("FAIL bp_drain: got %h v=%b want 006 0", out, out_valid); end
    step();
    mon_en = 1'b0;
    total++;
    if (mon_q.size() != 2 || mon_q[0] !== 12'h005 || mon_q[1] !== 12'h006) begin
      bad++; $display("FAIL bp_scoreboard: got n=%0d first=%h second=%h want 2 005 006",
                      mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 12'hxxx, (mon_q.size() > 1) ? mon_q[1] : 12'hxxx);
    end
    sat_mode = 1'b1; in = '0;
  endtask

  task automatic test_counter_sat_clear();
    sat_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in = 16'h4000;
    for (int i = 0; i < 300; i++) step();
    total++; if (ovf_count !== 8'hFF || ovf_sticky !== 1'b1) begin bad++; $display("FAIL cnt_sat: got %h s=%b want ff 1", ovf_count, ovf_sticky); end
    in_valid = 1'b0; clr = 1'b1;
    step();
    total++; if (ovf_count !== 8'h00 || ovf_sticky !== 1'b0) begin bad++; $display("FAIL clr_alone: got %h s=%b want 00 0", ovf_count, ovf_sticky); end
    total++; if (out !== 12'h7FF || out_ovf !== 1'b1) begin bad++; $display("FAIL clr_no_out_effect: got %h o=%b want 7ff 1", out, out_ovf); end
    clr = 1'b0; in_valid = 1'b1; in = 16'hC000;
    step(); step();
    total++; if (ovf_count !== 8'd2) begin bad++; $display("FAIL cnt_pre_clr: got %0d want 2", ovf_count); end
    clr = 1'b1; in = 16'h2000;
    step();
    total++; if (ovf_count !== 8'd1 || ovf_sticky !== 1'b1) begin bad++; $display("FAIL clr_with_ovf: got %0d s=%b want 1 1", ovf_count, ovf_sticky); end
    total++; if (out !== 12'h7FF || out_ovf !== 1'b1) begin bad++; $display("FAIL clr_ovf_out: got %h o=%b want 7ff 1", out, out_ovf); end
    clr = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset_stall();
    sat_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in = 16'h1000;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || out !== 12'h7FF || ovf_count !== 8'd2) begin bad++; $display("FAIL ar_pre: got %h v=%b c=%0d want 7ff 1 2", out, out_valid, ovf_count); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out !== 12'h000 || out_ovf !== 1'b0) begin bad++; $display("FAIL ar_out: got %h v=%b o=%b want 000 0 0", out, out_valid, out_ovf); end
    total++; if (ovf_count !== 8'h00 || ovf_sticky !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL ar_cnt: got c=%h s=%b r=%b want 00 0 1", ovf_count, ovf_sticky, in_ready); end
    #1;
    rst_n = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_no_spurious: got v=%b want 0", out_valid); end
    in_valid = 1'b1; in = 16'h0042; out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out !== 12'h042) begin bad++; $display("FAIL ar_resume: got %h v=%b want 042 1", out, out_valid); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_range_edges();
    test_wrap();
    test_back_to_back_stall();
    test_counter_sat_clear();
    test_async_reset_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/se_narrow_16b_12b.md
Name: se_narrow_16b_12b

Overview:
- Registered narrowing unit: the inverse of 12b->16b sign extension.
- Accepts 16-bit signed values, for example ALU results or assembler-computed offsets destined for 12-bit immediate/branch-offset fields.
- Produces 12-bit signed values, with overflow detection and selectable saturate or wrap.
- Single output stage with valid/ready handshake, plus sticky overflow flag and saturating overflow counter for debug/verification.

Parameters:
- CNT_W, 8, width of overflow event counter.

Ports:
- clk      input   1        system clock, rising edge.
- rst_n    input   1        asynchronous active-low reset.
- in       input   16       signed 16-bit value to narrow.
- in_valid input   1        in is valid this cycle.
- in_ready output  1        block can accept in this cycle.
- sat_mode input   1        1 = saturate on overflow; 0 = wrap (truncate to in[11:0]). Sampled with in.
- clr      input   1        synchronous clear of ovf_sticky and ovf_count.
- out      output  12       signed 12-bit narrowed value.
- out_ovf  output  1        out's source did not fit in 12 bits. Qualified by out_valid.
- out_valid output 1        out/out_ovf hold a valid result.
- out_ready input  1        downstream accepts out this cycle.
- ovf_sticky output 1       set by any accepted overflowing input; cleared by clr.
- ovf_count output CNT_W    number of accepted overflowing inputs, saturating at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - out = 12'h000, out_ovf = 0, out_valid = 0.
  - ovf_sticky = 0, ovf_count = 0.
  - in_ready is driven combinationally and equals 1 while out_valid = 0.
- Fit test: in fits iff in[15:11] are all 0 or all 1 (range -2048..2047). ovf = !fit.
- Narrowing function:
  - fit: result = in[11:0].
  - !fit and sat_mode = 1: result = 12'h7FF if in[15] = 0, 12'h800 if in[15] = 1.
  - !fit and sat_mode = 0: result = in[11:0] (wrap).
- Handshake:
  - in_ready = !out_valid || out_ready. Combinational; no combinational path from in_valid to in_ready.
  - Accept: in_valid && in_ready at a rising edge.
    - Registers result into out and ovf into out_ovf.
    - Sets out_valid = 1.
  - Latency: 1 cycle. A value accepted at edge N is visible on out at edge N.
  - Full throughput: back-to-back accepts every cycle while out_ready = 1.
  - Drain: out_valid && out_ready && !(in_valid && in_ready) -> out_valid = 0 next edge. out and out_ovf keep their last value.
  - Stall: out_valid && !out_ready -> out and out_ovf held stable and in_ready = 0. in is ignored even if in_valid = 1.
  - Simultaneous drain and accept in the same cycle: new result replaces old; out_valid stays 1.
- Counters (updated only on accept):
  - On accept with ovf = 1: ovf_sticky = 1; ovf_count increments unless already all-ones (saturate, no wrap).
  - clr = 1 with no overflowing accept: ovf_sticky = 0, ovf_count = 0.
  - clr = 1 with an overflowing accept in the same cycle: ovf_sticky = 1, ovf_count = 1. The set wins.
  - clr does not affect out, out_ovf, out_valid or in_ready.
- Reset mid-stall: the pending output is discarded (out_valid = 0) and the counters are zeroed; no spurious accept occurs on the first edge after rst_n deasserts unless in_valid = 1.
- X-safety: in and sat_mode are don't-care when in_valid = 0; none of the registered outputs changes.

Test Plan:
- Reset then pass-through: in = 16'h0123, in_valid = 1, out_ready = 1 -> next cycle out = 12'h123, out_ovf = 0, out_valid = 1. Then in = 16'hFFE1 -> out = 12'hFE1, out_ovf = 0.
- Range edges, sat_mode = 1:
  - 16'h07FF -> 12'h7FF, ovf 0.
  - 16'hF800 -> 12'h800, ovf 0.
  - 16'h0800 -> 12'h7FF, ovf 1.
  - 16'hF7FF -> 12'h800, ovf 1.
  - 16'h7FFF -> 12'h7FF, ovf 1.
  - Result after the sequence: ovf_count = 3, ovf_sticky = 1.
- Wrap mode, sat_mode = 0: 16'h1234 -> out = 12'h234, ovf 1; 16'h8000 -> out = 12'h000, ovf 1.
- Backpressure: accept 16'h0005, then hold out_ready = 0 for 3 cycles with in_valid = 1, in = 16'h0006 -> in_ready = 0 and out stays 12'h005. Raise out_ready -> 12'h006 appears next edge; the bench scoreboard sees no loss or duplication.
- Counter saturation and clear:
  - 300 overflowing accepts -> ovf_count = 8'hFF.
  - clr alone -> 0 and ovf_sticky = 0.
  - clr together with an overflowing accept -> ovf_count = 1, ovf_sticky = 1.
- Async reset mid-stall: out_valid = 1, out_ready = 0, assert rst_n = 0 between edges -> out_valid = 0, out = 12'h000 and counters = 0 immediately, with no edge required.
